// File: rtl/enemy_wave_controller.sv
// Enemy wave controller: four lane slots that spawn at a fixed frame interval,
// march right each frame, and leave by escaping past END_X or being hit.
// Also resolves which enemy (if any) owns the current scan pixel.
module enemy_wave_controller #(
    parameter int SPAWN_FRAMES = 60,
    parameter int WAVE_SIZE    = 8,
    parameter int SPEED        = 2,
    parameter int START_X      = 0,
    parameter int END_X        = 608,
    parameter int LANE_Y       = 208,
    parameter int LANE_STEP    = 48,
    parameter int ENEMY_W      = 32,
    parameter int ENEMY_H      = 32
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        enable,
    input  logic        startOfFrame,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    input  logic        hitValid,
    input  logic [1:0]  hitSlot,
    output logic [10:0] offsetX,
    output logic [10:0] offsetY,
    output logic        InsideRectangle,
    output logic [1:0]  activeSlot,
    output logic [2:0]  enemyCount,
    output logic        escapeP,
    output logic        waveDone
);

    localparam int CNT_W = (SPAWN_FRAMES > 1) ? $clog2(SPAWN_FRAMES) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [3:0]       slotActive;
    logic [10:0]      slotX [4];
    logic [CNT_W-1:0] spawnCnt;
    logic [3:0]       spawned;

    logic [3:0]       hitMask;
    logic [3:0]       liveMask;
    logic [3:0]       nextActive;
    logic [10:0]      nextX [4];
    logic [CNT_W-1:0] nextCnt;
    logic [3:0]       nextSpawned;
    logic             escAny;
    logic             freeFound;
    logic [1:0]       freeIdx;
    logic             waveEmpty;

    logic             ownVld_p0;
    logic [1:0]       ownSlot_p0;
    logic [10:0]      ownOffX_p0;
    logic [10:0]      ownOffY_p0;

    // Top edge of a lane, widened to 12 bits so bottom-edge sums cannot wrap.
    function automatic logic [11:0] laneY(input int i);
        return 12'(LANE_Y + i * LANE_STEP);
    endfunction

    function automatic logic [2:0] popCount(input logic [3:0] v);
        return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

    assign waveEmpty = (spawned == 4'(WAVE_SIZE)) && (slotActive == 4'b0);

    // Next slot picture for one RUN cycle: hit first, then move, then spawn.
    always_comb begin
        hitMask = 4'b0;
        if (hitValid) hitMask[hitSlot] = slotActive[hitSlot];
        liveMask    = slotActive & ~hitMask;
        nextActive  = liveMask;
        nextCnt     = spawnCnt;
        nextSpawned = spawned;
        escAny      = 1'b0;
        freeFound   = 1'b0;
        freeIdx     = 2'd0;
        for (int i = 0; i < 4; i++) nextX[i] = slotX[i];
        // A slot freed by a hit this cycle is available for the spawn.
        for (int i = 3; i >= 0; i--) begin
            if (!liveMask[i]) begin
                freeFound = 1'b1;
                freeIdx   = 2'(i);
            end
        end
        if (startOfFrame) begin
            // Only slots alive before this frame's spawn move, so a fresh
            // enemy sits at START_X for a full frame.
            for (int i = 0; i < 4; i++) begin
                if (liveMask[i]) begin
                    if ({1'b0, slotX[i]} + 12'(SPEED) >= 12'(END_X)) begin
                        nextActive[i] = 1'b0;
                        escAny        = 1'b1;
                    end else begin
                        nextX[i] = slotX[i] + 11'(SPEED);
                    end
                end
            end
            if (spawnCnt == CNT_W'(SPAWN_FRAMES - 1)) begin
                // Counter parks here until a spawn succeeds, so a blocked
                // spawn is retried on every following frame.
                if ((spawned < 4'(WAVE_SIZE)) && freeFound) begin
                    nextActive[freeIdx] = 1'b1;
                    nextX[freeIdx]      = 11'(START_X);
                    nextCnt             = '0;
                    nextSpawned         = spawned + 4'd1;
                end
            end else begin
                nextCnt = spawnCnt + CNT_W'(1);
            end
        end
    end

    // Wave FSM with slot state, escape pulse and done flag.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state      <= IDLE;
            slotActive <= 4'b0;
            for (int i = 0; i < 4; i++) slotX[i] <= 11'd0;
            spawnCnt   <= '0;
            spawned    <= 4'd0;
            escapeP    <= 1'b0;
            waveDone   <= 1'b0;
        end else begin
            escapeP <= 1'b0;
            case (state)
                IDLE: begin
                    slotActive <= 4'b0;
                    spawnCnt   <= '0;
                    spawned    <= 4'd0;
                    waveDone   <= 1'b0;
                    if (enable) state <= RUN;
                end
                RUN: begin
                    if (!enable) begin
                        state      <= IDLE;
                        slotActive <= 4'b0;
                        spawnCnt   <= '0;
                        spawned    <= 4'd0;
                    end else if (waveEmpty) begin
                        state    <= DONE;
                        waveDone <= 1'b1;
                    end else begin
                        slotActive <= nextActive;
                        slotX      <= nextX;
                        spawnCnt   <= nextCnt;
                        spawned    <= nextSpawned;
                        escapeP    <= escAny;
                    end
                end
                DONE: begin
                    if (!enable) begin
                        state    <= IDLE;
                        waveDone <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Pixel owner search; scanning downward lets the lowest index win overlaps.
    always_comb begin
        ownVld_p0  = 1'b0;
        ownSlot_p0 = 2'd0;
        ownOffX_p0 = 11'd0;
        ownOffY_p0 = 11'd0;
        for (int i = 3; i >= 0; i--) begin
            if (slotActive[i]
                && ({1'b0, pixelX} >= {1'b0, slotX[i]})
                && ({1'b0, pixelX} <  {1'b0, slotX[i]} + 12'(ENEMY_W))
                && ({1'b0, pixelY} >= laneY(i))
                && ({1'b0, pixelY} <  laneY(i) + 12'(ENEMY_H))) begin
                ownVld_p0  = 1'b1;
                ownSlot_p0 = 2'(i);
                ownOffX_p0 = pixelX - slotX[i];
                ownOffY_p0 = pixelY - 11'(laneY(i));
            end
        end
    end

    // Stage p0 -> p1: registered pixel-owner outputs.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            InsideRectangle <= 1'b0;
            activeSlot      <= 2'd0;
            offsetX         <= 11'd0;
            offsetY         <= 11'd0;
        end else begin
            InsideRectangle <= ownVld_p0;
            activeSlot      <= ownSlot_p0;
            offsetX         <= ownOffX_p0;
            offsetY         <= ownOffY_p0;
        end
    end

    // Live enemy count, trailing slot changes by one cycle.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) enemyCount <= 3'd0;
        else         enemyCount <= popCount(slotActive);
    end

endmodule

// File: tb/tb_enemy_wave_controller.sv
// Bench for enemy_wave_controller: two instances (wave of 8 and wave of 2)
// share frame/pixel/enable stimulus, each with its own hit port, and are
// compared every cycle against a behavioural wave model.
module tb_enemy_wave_controller;

    localparam int SF   = 4;
    localparam int SPD  = 2;
    localparam int ENDX = 608;

    logic             clk = 1'b0;
    logic             resetN;
    logic             enable;
    logic             sof;
    logic [10:0]      pX;
    logic [10:0]      pY;
    logic [1:0]       hv;
    logic [1:0][1:0]  hs;
    logic [1:0][10:0] offX;
    logic [1:0][10:0] offY;
    logic [1:0]       ins;
    logic [1:0][1:0]  aslot;
    logic [1:0][2:0]  cnt;
    logic [1:0]       esc;
    logic [1:0]       done;

    int nChecks = 0;
    int nFails  = 0;

    // Model: phase 0 idle, 1 running, 2 finished.
    int mPhase [2];
    bit mAlive [2][4];
    int mX     [2][4];
    int mFrames[2];
    int mSpawned[2];
    int eIns[2], eSlot[2], eOffX[2], eOffY[2], eCnt[2], eEsc[2], eDone[2];

    always #5 clk = ~clk;

    enemy_wave_controller #(.SPAWN_FRAMES(SF), .WAVE_SIZE(8)) dutA (
        .clk(clk), .resetN(resetN), .enable(enable), .startOfFrame(sof),
        .pixelX(pX), .pixelY(pY), .hitValid(hv[0]), .hitSlot(hs[0]),
        .offsetX(offX[0]), .offsetY(offY[0]), .InsideRectangle(ins[0]),
        .activeSlot(aslot[0]), .enemyCount(cnt[0]), .escapeP(esc[0]),
        .waveDone(done[0])
    );

    enemy_wave_controller #(.SPAWN_FRAMES(SF), .WAVE_SIZE(2)) dutB (
        .clk(clk), .resetN(resetN), .enable(enable), .startOfFrame(sof),
        .pixelX(pX), .pixelY(pY), .hitValid(hv[1]), .hitSlot(hs[1]),
        .offsetX(offX[1]), .offsetY(offY[1]), .InsideRectangle(ins[1]),
        .activeSlot(aslot[1]), .enemyCount(cnt[1]), .escapeP(esc[1]),
        .waveDone(done[1])
    );

    function automatic int waveOf(input int d);
        return (d == 0) ? 8 : 2;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        for (int d = 0; d < 2; d++) begin
            mPhase[d] = 0; mFrames[d] = 0; mSpawned[d] = 0;
            for (int i = 0; i < 4; i++) begin mAlive[d][i] = 0; mX[d][i] = 0; end
            eIns[d] = 0; eSlot[d] = 0; eOffX[d] = 0; eOffY[d] = 0;
            eCnt[d] = 0; eEsc[d] = 0; eDone[d] = 0;
        end
    endtask

    // One clock of the wave rules for instance d.
    task automatic modelStep(input int d);
        int px, py, ly, alive, spawnAt, hsl;
        bit found, movers[4];
        px = int'(pX); py = int'(pY);
        found = 0;
        eIns[d] = 0; eSlot[d] = 0; eOffX[d] = 0; eOffY[d] = 0;
        alive = 0;
        for (int i = 0; i < 4; i++) begin
            ly = 208 + 48 * i;
            if (mAlive[d][i]) alive++;
            if (!found && mAlive[d][i] && px >= mX[d][i] && px < mX[d][i] + 32
                && py >= ly && py < ly + 32) begin
                found = 1; eIns[d] = 1; eSlot[d] = i;
                eOffX[d] = px - mX[d][i]; eOffY[d] = py - ly;
            end
        end
        eCnt[d] = alive;
        eEsc[d] = 0;
        case (mPhase[d])
            0: begin
                for (int i = 0; i < 4; i++) mAlive[d][i] = 0;
                mFrames[d] = 0; mSpawned[d] = 0;
                if (enable) mPhase[d] = 1;
            end
            1: begin
                if (!enable) begin
                    for (int i = 0; i < 4; i++) mAlive[d][i] = 0;
                    mFrames[d] = 0; mSpawned[d] = 0; mPhase[d] = 0;
                end else if (mSpawned[d] == waveOf(d) && alive == 0) begin
                    mPhase[d] = 2;
                end else begin
                    hsl = int'(hs[d]);
                    if (hv[d] && mAlive[d][hsl]) mAlive[d][hsl] = 0;
                    if (sof) begin
                        spawnAt = -1;
                        if (mFrames[d] == SF - 1) begin
                            if (mSpawned[d] < waveOf(d))
                                for (int i = 0; i < 4; i++)
                                    if (spawnAt < 0 && !mAlive[d][i]) spawnAt = i;
                            if (spawnAt >= 0) begin mFrames[d] = 0; mSpawned[d]++; end
                        end else begin
                            mFrames[d]++;
                        end
                        for (int i = 0; i < 4; i++) movers[i] = mAlive[d][i];
                        for (int i = 0; i < 4; i++) begin
                            if (movers[i]) begin
                                if (mX[d][i] + SPD >= ENDX) begin mAlive[d][i] = 0; eEsc[d] = 1; end
                                else mX[d][i] += SPD;
                            end
                        end
                        if (spawnAt >= 0) begin mAlive[d][spawnAt] = 1; mX[d][spawnAt] = 0; end
                    end
                end
            end
            default: if (!enable) mPhase[d] = 0;
        endcase
        eDone[d] = (mPhase[d] == 2) ? 1 : 0;
    endtask

    task automatic checkAll();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("inside%0d", d), 32'(ins[d]),   eIns[d]);
            chk($sformatf("slot%0d", d),   32'(aslot[d]), eSlot[d]);
            chk($sformatf("offX%0d", d),   32'(offX[d]),  eOffX[d]);
            chk($sformatf("offY%0d", d),   32'(offY[d]),  eOffY[d]);
            chk($sformatf("count%0d", d),  32'(cnt[d]),   eCnt[d]);
            chk($sformatf("escape%0d", d), 32'(esc[d]),   eEsc[d]);
            chk($sformatf("done%0d", d),   32'(done[d]),  eDone[d]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!resetN) modelReset();
        else begin modelStep(0); modelStep(1); end
        @(negedge clk);
        checkAll();
    endtask

    task automatic frame();
        sof = 1'b1; tick();
        sof = 1'b0; tick();
    endtask

    initial begin
        resetN = 1'b0; enable = 1'b0; sof = 1'b0;
        pX = 11'd0; pY = 11'd0; hv = 2'b00; hs = '0;
        modelReset();
        tick(); tick();
        chk("rst_count", 32'(cnt[0]), 0);
        chk("rst_done", 32'(done[1]), 0);
        resetN = 1'b1;
        tick(); frame(); frame();
        chk("idle_count", 32'(cnt[0]), 0);

        // First spawn after SF frames, then one step right.
        enable = 1'b1; tick();
        repeat (4) frame();
        chk("spawn_count", 32'(cnt[0]), 1);
        pX = 11'd0; pY = 11'd208; tick();
        chk("spawn_x0_inside", 32'(ins[0]), 1);
        chk("spawn_x0_offx", 32'(offX[0]), 0);
        frame();
        pX = 11'd1; tick();
        chk("moved_left_edge", 32'(ins[0]), 0);
        pX = 11'd33; tick();
        chk("moved_offx", 32'(offX[0]), 31);

        // Slot 0 at x=10.
        repeat (4) frame();
        pX = 11'd15; pY = 11'd210; tick();
        chk("pix_inside", 32'(ins[0]), 1);
        chk("pix_slot", 32'(aslot[0]), 0);
        chk("pix_offx", 32'(offX[0]), 5);
        chk("pix_offy", 32'(offY[0]), 2);
        pX = 11'd42; tick();
        chk("pix_right_edge", 32'(ins[0]), 0);
        chk("pix_right_offx", 32'(offX[0]), 0);

        // Kill both enemies of the two-enemy wave.
        hv[1] = 1'b1; hs[1] = 2'd0; tick();
        hs[1] = 2'd1; tick();
        hv[1] = 1'b0; tick();
        chk("waveB_done", 32'(done[1]), 1);
        chk("waveA_not_done", 32'(done[0]), 0);

        // Fill all four slots; blocked spawn waits, then fills a hit slot.
        repeat (11) frame();
        chk("full_count", 32'(cnt[0]), 4);
        hv[0] = 1'b1; hs[0] = 2'd2; tick();
        hv[0] = 1'b0;
        frame();
        pX = 11'd3; pY = 11'd305; tick();
        chk("respawn_inside", 32'(ins[0]), 1);
        chk("respawn_slot", 32'(aslot[0]), 2);
        chk("respawn_offx", 32'(offX[0]), 3);
        chk("respawn_count", 32'(cnt[0]), 4);

        // Escape of slot 0, then slot 1 escaping while hit.
        for (int k = 0; k < 400 && !(mAlive[0][0] && mX[0][0] == 606); k++) frame();
        chk("reach606_s0", 32'(mAlive[0][0] && mX[0][0] == 606), 1);
        sof = 1'b1; tick();
        chk("escape_pulse", 32'(esc[0]), 1);
        sof = 1'b0; tick();
        chk("escape_single", 32'(esc[0]), 0);
        for (int k = 0; k < 400 && !(mAlive[0][1] && mX[0][1] == 606); k++) frame();
        chk("reach606_s1", 32'(mAlive[0][1] && mX[0][1] == 606), 1);
        sof = 1'b1; hv[0] = 1'b1; hs[0] = 2'd1; tick();
        chk("hit_beats_escape", 32'(esc[0]), 0);
        sof = 1'b0; hv[0] = 1'b0; tick();

        // Asynchronous reset in the middle of a wave.
        #2 resetN = 1'b0; enable = 1'b0;
        modelReset();
        #1;
        chk("arst_count", 32'(cnt[0]), 0);
        chk("arst_inside", 32'(ins[0]), 0);
        chk("arst_done", 32'(done[1]), 0);
        chk("arst_escape", 32'(esc[0]), 0);
        tick();
        resetN = 1'b1;
        repeat (6) frame();
        chk("post_rst_idle", 32'(cnt[0]), 0);
        chk("post_rst_done", 32'(done[1]), 0);

        // Randomised operation.
        for (int c = 0; c < 3000; c++) begin
            enable = ($urandom_range(0, 299) != 0);
            sof    = ($urandom_range(0, 2) == 0);
            hv[0]  = ($urandom_range(0, 9) == 0);
            hv[1]  = ($urandom_range(0, 9) == 0);
            hs[0]  = 2'($urandom_range(0, 3));
            hs[1]  = 2'($urandom_range(0, 3));
            pX     = 11'($urandom_range(0, 660));
            pY     = 11'($urandom_range(180, 400));
            tick();
        end

        // Drive the small wave to completion, then release enable.
        enable = 1'b1; hv[0] = 1'b0;
        for (int k = 0; k < 4000 && mPhase[1] != 2; k++) begin
            sof = (k % 2 == 0); hv[1] = 1'b1; hs[1] = 2'(k % 4);
            tick();
        end
        sof = 1'b0; hv[1] = 1'b0;
        chk("final_done", 32'(done[1]), 1);
        enable = 1'b0; tick();
        chk("final_done_clear", 32'(done[1]), 0);
        chk("final_doneA_clear", 32'(done[0]), 0);
        tick();
        chk("final_count", 32'(cnt[0]), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
